led_serial_receiver: RTL
========================

// Module: led_serial_receiver
// PURPOSE
//  Deserializes the 3-wire LED serial stream (serial clock, data, active-low latch) back into a parallel word.
//  Sits on the far end of the LED serial link: board-side LED controller emulation and loopback/self-test of the LED driver.
//  Inputs are asynchronous to i_CLK; the block synchronizes them, shifts bits in on serial-clock rising edges and commits on latch release.
//  Detects malformed frames (wrong bit count) and counts good frames.
// PARAMETERS
//  WIDTH        16  frame length in bits; also o_Data width
//  SWAP_HALVES  1   1: k-th received bit (k=0 first) lands at index k^(WIDTH/2); 0: lands at index k
//  SYNC_STAGES  2   synchronizer depth for i_SCK/i_SDATA/i_LATCH_N (>=2)
// PORTS
//  i_CLK       in   1      system clock; must be >= 4x serial clock rate
//  i_RESET     in   1      synchronous, active-high
//  i_SCK       in   1      serial clock from link; data valid at its rising edge
//  i_SDATA     in   1      serial data from link
//  i_LATCH_N   in   1      active-low latch; frame commits on its rising edge (deassertion)
//  o_Data      out  WIDTH  last good frame, held until next good frame
//  o_Valid     out  1      1-cycle pulse when o_Data updated
//  o_FrameErr  out  1      1-cycle pulse when a latch arrives with bit count != WIDTH
//  o_FrameCnt  out  8      count of good frames, wraps 255->0
//  o_Busy      out  1      1 while bit count != 0 (partial frame in progress)
// BEHAVIOUR
//  Reset (i_RESET=1 at posedge i_CLK): o_Data=0, o_Valid=0, o_FrameErr=0, o_FrameCnt=0, o_Busy=0,
//   shift reg=0, bit count=0; sync flops load idle levels SCK=0, SDATA=0, LATCH_N=1 (no spurious edge after reset).
//  Reset mid-frame: partial bits discarded, no o_Valid/o_FrameErr pulse.
//  Sync: all three inputs pass through SYNC_STAGES flops in parallel (same depth -> SDATA aligned to SCK).
//   Edge detect uses one extra registered copy of the synchronized SCK and LATCH_N.
//  Shift: on synchronized SCK rising edge while synchronized LATCH_N=1: sampled SDATA written to
//   shift-reg index (cnt ^ WIDTH/2) if SWAP_HALVES else index cnt; cnt increments, saturating at WIDTH+1.
//   Bits beyond WIDTH are not written (shift reg holds first WIDTH bits).
//  SCK rising edges while synchronized LATCH_N=0: ignored (no shift, no count change).
//  Commit: on synchronized LATCH_N rising edge:
//   cnt==WIDTH -> next cycle o_Data<=shift reg, o_Valid=1, o_FrameCnt+=1 (mod 256).
//   cnt!=WIDTH (incl. 0, i.e. latch with no bits) -> next cycle o_FrameErr=1; o_Data, o_FrameCnt unchanged.
//   Either case: cnt<=0, shift reg<=0.
//  Simultaneous SCK rise and LATCH_N rise in same synced cycle: shift is applied first, the bit is
//   included in the count checked for commit.
//  Latency: pin LATCH_N rise -> o_Valid high = SYNC_STAGES+2 i_CLK edges (sync + edge detect + output register).
//  o_Valid and o_FrameErr never high in the same cycle; both are exactly 1 cycle wide.
//  Latch falling edge has no effect; only its release commits. o_Busy = (cnt!=0), registered.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1. Reset, send 16 bits so that frame value 0xA5C3 arrives with SWAP_HALVES=1 (first bit = bit 8),
//     pulse LATCH_N -> o_Data=16'hA5C3, one o_Valid pulse, o_FrameCnt=1, o_FrameErr=0.
//  2. Same stimulus with SWAP_HALVES=0, bits sent LSB first for 0x00FF -> o_Data=16'h00FF.
//  3. Send 15 bits then latch -> o_FrameErr pulse, o_Data keeps prior 16'hA5C3, o_FrameCnt unchanged;
//     repeat with 17 bits -> same error response; next correct frame 0x1234 -> o_Valid, o_Data=16'h1234.
//  4. Assert i_RESET after 8 bits, release, send full frame 0xFFFF + latch -> o_Data=16'hFFFF,
//     o_FrameCnt=1; no pulses during or right after reset.
//  5. Last SCK rise and LATCH_N rise in same i_CLK cycle -> frame accepted (16 bits counted), o_Valid=1;
//     SCK edges while LATCH_N low -> ignored, count unaffected.
//  6. 256 consecutive good frames -> o_FrameCnt wraps to 0; measure o_Valid at SYNC_STAGES+2 edges after latch rise.

Source files
------------

// File: rtl/led_serial_receiver.sv
// LED serial link receiver: synchronizes SCK/SDATA/LATCH_N, shifts bits in
// on SCK rise and commits the frame on latch release.
module led_serial_receiver #(
    parameter int WIDTH       = 16,
    parameter int SWAP_HALVES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_SCK,
    input  logic             i_SDATA,
    input  logic             i_LATCH_N,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Valid,
    output logic             o_FrameErr,
    output logic [7:0]       o_FrameCnt,
    output logic             o_Busy
);
    localparam int IW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [IW-1:0] HALF     = IW'(WIDTH / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] latch_sync;
    logic                   sck_d;
    logic                   latch_d;
    logic                   sck_s;
    logic                   latch_s;

    logic                   sck_rise_r;
    logic                   latch_rise_r;
    logic                   latch_r;
    logic                   sdata_r;

    logic [WIDTH-1:0]       shift_q;
    logic [WIDTH-1:0]       shift_n;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_n;
    logic [IW-1:0]          idx;

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign latch_s = latch_sync[SYNC_STAGES-1];

    // Idle levels on reset so no edge is seen when reset releases.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            sck_sync     <= '0;
            sdata_sync   <= '0;
            latch_sync   <= '1;
            sck_d        <= 1'b0;
            latch_d      <= 1'b1;
            sck_rise_r   <= 1'b0;
            latch_rise_r <= 1'b0;
            latch_r      <= 1'b1;
            sdata_r      <= 1'b0;
        end else begin
            sck_sync     <= {sck_sync[SYNC_STAGES-2:0], i_SCK};
            sdata_sync   <= {sdata_sync[SYNC_STAGES-2:0], i_SDATA};
            latch_sync   <= {latch_sync[SYNC_STAGES-2:0], i_LATCH_N};
            sck_d        <= sck_s;
            latch_d      <= latch_s;
            sck_rise_r   <= sck_s & ~sck_d;
            latch_rise_r <= latch_s & ~latch_d;
            latch_r      <= latch_s;
            sdata_r      <= sdata_sync[SYNC_STAGES-1];
        end
    end

    assign idx = (SWAP_HALVES != 0) ? (cnt_q[IW-1:0] ^ HALF)
                                    : cnt_q[IW-1:0];

    // Shift applied before commit so a bit coinciding with latch counts.
    always_comb begin
        shift_n = shift_q;
        cnt_n   = cnt_q;
        if (sck_rise_r && latch_r) begin
            if (cnt_q < CNT_FULL) begin
                shift_n[idx] = sdata_r;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            o_Data     <= '0;
            o_Valid    <= 1'b0;
            o_FrameErr <= 1'b0;
            o_FrameCnt <= '0;
            o_Busy     <= 1'b0;
        end else begin
            o_Valid    <= 1'b0;
            o_FrameErr <= 1'b0;
            if (latch_rise_r) begin
                shift_q <= '0;
                cnt_q   <= '0;
                o_Busy  <= 1'b0;
                if (cnt_n == CNT_FULL) begin
                    o_Data     <= shift_n;
                    o_Valid    <= 1'b1;
                    o_FrameCnt <= o_FrameCnt + 8'd1;
                end else begin
                    o_FrameErr <= 1'b1;
                end
            end else begin
                shift_q <= shift_n;
                cnt_q   <= cnt_n;
                o_Busy  <= (cnt_n != '0);
            end
        end
    end
endmodule
